// File: rtl/btn_event_decoder.sv
// Push-button front end: synchronizes and debounces a raw button, then
// classifies presses into one-cycle SHORT, LONG and DOUBLE event strobes.
module btn_event_decoder #(
    parameter int unsigned DEB_CYC  = 1_000_000,
    parameter int unsigned LONG_CYC = 50_000_000,
    parameter int unsigned GAP_CYC  = 25_000_000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic PRESSED,
    output logic SHORT,
    output logic LONG,
    output logic DOUBLE
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DOWN1,
        UP1,
        HELD
    } state_t;

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] dcnt;
    logic             prev;
    logic             rise;
    logic             fall;
    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] tmr;
    logic             short_n;
    logic             long_n;
    logic             double_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= BTN;
            s2 <= s1;
        end
    end

    // PRESSED only follows s2 after it has disagreed for DEB_CYC straight cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dcnt    <= '0;
            PRESSED <= 1'b0;
        end else if (s2 == PRESSED) begin
            dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
            PRESSED <= s2;
            dcnt    <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev <= 1'b0;
        end else begin
            prev <= PRESSED;
        end
    end

    assign rise = PRESSED & ~prev;
    assign fall = ~PRESSED & prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Timeouts win in DOWN1, but a second press beats the gap timeout in UP1.
    always_comb begin
        state_n  = state_q;
        short_n  = 1'b0;
        long_n   = 1'b0;
        double_n = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_n = DOWN1;
                end
            end
            DOWN1: begin
                if (tmr == LONG_LAST) begin
                    long_n  = 1'b1;
                    state_n = HELD;
                end else if (fall) begin
                    state_n = UP1;
                end
            end
            UP1: begin
                if (rise) begin
                    double_n = 1'b1;
                    state_n  = HELD;
                end else if (tmr == GAP_LAST) begin
                    short_n = 1'b1;
                    state_n = IDLE;
                end
            end
            HELD: begin
                if (fall) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tmr <= '0;
        end else if (state_n != state_q) begin
            tmr <= '0;
        end else if (tmr != '1) begin
            tmr <= tmr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SHORT  <= 1'b0;
            LONG   <= 1'b0;
            DOUBLE <= 1'b0;
        end else begin
            SHORT  <= short_n;
            LONG   <= long_n;
            DOUBLE <= double_n;
        end
    end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: table of button patterns plus hand sequences,
// expected strobes queued with their cycle numbers and checked as they appear.
module tb_btn_event_decoder;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LNG  = 40;
    localparam int unsigned GAP  = 20;
    localparam int unsigned W    = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic BTN = 1'b0;
    logic PRESSED;
    logic SHORT;
    logic LONG;
    logic DOUBLE;

    btn_event_decoder #(
        .DEB_CYC (DEB),
        .LONG_CYC(LNG),
        .GAP_CYC (GAP),
        .CNT_W   (W)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BTN    (BTN),
        .PRESSED(PRESSED),
        .SHORT  (SHORT),
        .LONG   (LONG),
        .DOUBLE (DOUBLE)
    );

    always #5 CLK = ~CLK;

    typedef enum int {K_NONE, K_SHORT, K_LONG, K_DOUBLE} kind_e;
    typedef struct {
        kind_e k;
        int    at;
    } exp_t;
    typedef struct {
        string name;
        int    h1;
        int    g;
        int    h2;
        int    pr;
        kind_e k0;
        int    o0;
        kind_e k1;
        int    o1;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   pressed_seen = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic expect_ev(input kind_e k, input int at);
        exp_t e;
        e.k  = k;
        e.at = at;
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic btn_level);
        RST = 1'b1;
        BTN = btn_level;
        step(2);
        RST = 1'b0;
        chk("reset_outputs", int'({PRESSED, SHORT, LONG, DOUBLE}), 0);
    endtask

    task automatic drain(input string name);
        chk({name, "_missing_events"}, sb.size(), 0);
        sb.delete();
    endtask

    // Pulses are sampled mid-cycle; the cycle number is the edge that produced them.
    always @(negedge CLK) begin : mon
        kind_e k;
        exp_t  e;
        if (PRESSED) pressed_seen = 1;
        if (SHORT || LONG || DOUBLE) begin
            chk("one_hot", $countones({SHORT, LONG, DOUBLE}), 1);
            k = SHORT ? K_SHORT : (LONG ? K_LONG : K_DOUBLE);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", int'(k), int'(K_NONE));
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", int'(k), int'(e.k));
                chk("pulse_cycle", cyc, e.at);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int n;
        do_reset(1'b0);
        pressed_seen = 0;
        n = cyc;
        if (v.k0 != K_NONE) expect_ev(v.k0, n + v.o0);
        if (v.k1 != K_NONE) expect_ev(v.k1, n + v.o1);
        BTN = 1'b1;
        step(v.h1);
        BTN = 1'b0;
        if (v.h2 > 0) begin
            step(v.g);
            BTN = 1'b1;
            step(v.h2);
            BTN = 1'b0;
        end
        step(90);
        chk({v.name, "_pressed_seen"}, pressed_seen, v.pr);
        drain(v.name);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int r;
        // Offsets from the edge after which BTN first rises: press seen by FSM at +7,
        // LONG at press+47, SHORT at release+27, DOUBLE at second press+7.
        vecs[0] = '{"glitch3",        3,  0,  0, 0, K_NONE,   0, K_NONE,  0};
        vecs[1] = '{"short15",        15, 0,  0, 1, K_SHORT,  42, K_NONE,  0};
        vecs[2] = '{"long60",         60, 0,  0, 1, K_LONG,   47, K_NONE,  0};
        vecs[3] = '{"double10",       10, 10, 10, 1, K_DOUBLE, 27, K_NONE,  0};
        vecs[4] = '{"double_gap_edge", 10, 20, 10, 1, K_DOUBLE, 37, K_NONE,  0};
        vecs[5] = '{"gap21_two_short", 10, 21, 10, 1, K_SHORT,  37, K_SHORT, 68};
        vecs[6] = '{"release_tmr38",  39, 0,  0, 1, K_SHORT,  66, K_NONE,  0};
        vecs[7] = '{"long_vs_fall",   40, 0,  0, 1, K_LONG,   47, K_NONE,  0};

        step(1);
        do_reset(1'b0);
        chk("idle_pressed", int'(PRESSED), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Two separate long holds, each giving its own LONG and nothing on release.
        do_reset(1'b0);
        n = cyc;
        expect_ev(K_LONG, n + 47);
        expect_ev(K_LONG, n + 117);
        BTN = 1'b1;
        step(60);
        BTN = 1'b0;
        step(10);
        BTN = 1'b1;
        step(60);
        BTN = 1'b0;
        step(60);
        drain("long_twice");

        // Reset in DOWN1 with tmr at 25, button kept high through reset release.
        do_reset(1'b0);
        BTN = 1'b1;
        step(32);
        do_reset(1'b1);
        r = cyc;
        expect_ev(K_SHORT, r + 42);
        step(5);
        chk("pressed_before_deb", int'(PRESSED), 0);
        step(1);
        chk("pressed_after_deb", int'(PRESSED), 1);
        step(9);
        BTN = 1'b0;
        step(60);
        drain("reset_mid_press");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
